// File: rtl/tracker_pkg.sv
// rtl/tracker_pkg.sv - shared states, motor modes and steering decode for the line tracker
package tracker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FORWARD = 3'd1,
        ST_LEFT    = 3'd2,
        ST_RIGHT   = 3'd3,
        ST_SEARCH  = 3'd4,
        ST_HALT    = 3'd5
    } state_t;

    typedef enum logic {
        SIDE_LEFT  = 1'b0,
        SIDE_RIGHT = 1'b1
    } side_t;

    localparam logic [1:0] MODE_STOP = 2'd0;
    localparam logic [1:0] MODE_FWD  = 2'd1;
    localparam logic [1:0] MODE_BWD  = 2'd2;

    // Steering choice from filtered {left, center, right}; 101 is ambiguous and
    // keeps the current heading (IDLE has no heading, so it starts forward).
    function automatic state_t steer_state(input logic [2:0] lcr, input state_t cur);
        state_t nxt;
        case (lcr)
            3'b010, 3'b111: nxt = ST_FORWARD;
            3'b100, 3'b110: nxt = ST_LEFT;
            3'b001, 3'b011: nxt = ST_RIGHT;
            3'b000:         nxt = ST_SEARCH;
            default:        nxt = (cur == ST_IDLE) ? ST_FORWARD : cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - 2-flop synchronizer plus stable-count debounce for a sensor bus
module sensor_debounce #(
    parameter int WIDTH           = 3,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] filtered
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LIM = CW'(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] cand;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;

    // Length of the current run of an unchanged candidate value, this clock included.
    always_comb begin
        cnt_next = CW'(1);
        if (sync2 == cand && cnt != '0) begin
            cnt_next = (cnt == CNT_LIM) ? cnt : cnt + CW'(1);
        end
    end

    // Synchronize, then commit a differing value only after it has stayed put long enough.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1    <= '0;
            sync2    <= '0;
            cand     <= '0;
            cnt      <= '0;
            filtered <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == filtered) begin
                cnt <= '0;
            end else begin
                cand <= sync2;
                if (cnt_next >= CNT_LIM) begin
                    filtered <= sync2;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt_next;
                end
            end
        end
    end

endmodule

// File: rtl/tracker_ctrl.sv
// rtl/tracker_ctrl.sv - line tracker steering FSM; TRACKER_CTRL_PIVOT_EN reverses the inner wheel on turns
module tracker_ctrl
    import tracker_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int LOST_TIMEOUT    = 200000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] sensor,
    output logic [1:0] l_mode,
    output logic [1:0] r_mode,
    output logic [2:0] state,
    output logic       lost
);

    localparam int SW = $clog2(LOST_TIMEOUT + 1);
    localparam logic [SW-1:0] SEARCH_LAST = SW'(LOST_TIMEOUT - 1);

`ifdef TRACKER_CTRL_PIVOT_EN
    localparam logic [1:0] INNER_MODE = MODE_BWD;
`else
    localparam logic [1:0] INNER_MODE = MODE_STOP;
`endif

    logic [2:0]    filt;
    state_t        state_q;
    state_t        state_next;
    side_t         last_side;
    logic [SW-1:0] search_cnt;

    sensor_debounce #(
        .WIDTH          (3),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .raw     (sensor),
        .filtered(filt)
    );

    // Next state: disable wins, HALT latches, a seen line beats the search timeout.
    always_comb begin
        state_next = state_q;
        if (!en) begin
            state_next = ST_IDLE;
        end else if (state_q == ST_HALT) begin
            state_next = ST_HALT;
        end else if (state_q == ST_SEARCH && filt == 3'b000 && search_cnt == SEARCH_LAST) begin
            state_next = ST_HALT;
        end else begin
            state_next = steer_state(filt, state_q);
        end
    end

    // State, search timer, last turn side and registered motor/debug outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            last_side  <= SIDE_LEFT;
            search_cnt <= '0;
            l_mode     <= MODE_STOP;
            r_mode     <= MODE_STOP;
            state      <= 3'd0;
            lost       <= 1'b0;
        end else begin
            state_q <= state_next;

            if (state_next == ST_SEARCH && state_q != ST_SEARCH) begin
                search_cnt <= '0;
            end else if (state_q == ST_SEARCH && search_cnt != SEARCH_LAST) begin
                search_cnt <= search_cnt + SW'(1);
            end

            if (state_next == ST_LEFT) begin
                last_side <= SIDE_LEFT;
            end else if (state_next == ST_RIGHT) begin
                last_side <= SIDE_RIGHT;
            end

            state <= state_q;
            lost  <= (state_q == ST_HALT);
            case (state_q)
                ST_FORWARD: begin
                    l_mode <= MODE_FWD;
                    r_mode <= MODE_FWD;
                end
                ST_LEFT: begin
                    l_mode <= INNER_MODE;
                    r_mode <= MODE_FWD;
                end
                ST_RIGHT: begin
                    l_mode <= MODE_FWD;
                    r_mode <= INNER_MODE;
                end
                ST_SEARCH: begin
                    if (last_side == SIDE_LEFT) begin
                        l_mode <= INNER_MODE;
                        r_mode <= MODE_FWD;
                    end else begin
                        l_mode <= MODE_FWD;
                        r_mode <= INNER_MODE;
                    end
                end
                default: begin
                    l_mode <= MODE_STOP;
                    r_mode <= MODE_STOP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tracker_ctrl.sv
// tb/tb_tracker_ctrl.sv - directed and randomized bench for tracker_ctrl against a behavioural model
module tb_tracker_ctrl;

    localparam int D = 4;
    localparam int T = 16;
`ifdef TRACKER_CTRL_PIVOT_EN
    localparam int INNER = 2;
`else
    localparam int INNER = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b1;
    logic [2:0] sensor = 3'b010;
    logic [1:0] l_mode;
    logic [1:0] r_mode;
    logic [2:0] state;
    logic       lost;

    int checks = 0;
    int errors = 0;

    // model: -1 in the table means "keep heading"
    int steer_tab [8] = '{4, 3, 1, 3, 2, -1, 2, 1};
    int hist [D];
    int d1, d2, m_filt;
    int m_state, m_side, m_cnt;
    int m_l, m_r, m_st, m_lost;

    tracker_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .LOST_TIMEOUT   (T)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .sensor(sensor),
        .l_mode(l_mode),
        .r_mode(r_mode),
        .state (state),
        .lost  (lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_step();
        int nxt;
        int t;
        bit same;
        if (!rst) begin
            m_state = 0; m_side = 0; m_cnt = 0; m_filt = 0; d1 = 0; d2 = 0;
            foreach (hist[i]) hist[i] = 0;
            m_l = 0; m_r = 0; m_st = 0; m_lost = 0;
        end else begin
            m_st   = m_state;
            m_lost = (m_state == 5) ? 1 : 0;
            case (m_state)
                1: begin m_l = 1; m_r = 1; end
                2: begin m_l = INNER; m_r = 1; end
                3: begin m_l = 1; m_r = INNER; end
                4: begin
                    if (m_side == 0) begin m_l = INNER; m_r = 1; end
                    else begin m_l = 1; m_r = INNER; end
                end
                default: begin m_l = 0; m_r = 0; end
            endcase
            if (!en) nxt = 0;
            else if (m_state == 5) nxt = 5;
            else if (m_state == 4 && m_filt == 0 && m_cnt == T - 1) nxt = 5;
            else begin
                t = steer_tab[m_filt];
                nxt = (t < 0) ? ((m_state == 0) ? 1 : m_state) : t;
            end
            if (nxt == 4 && m_state != 4) m_cnt = 0;
            else if (m_state == 4 && m_cnt < T - 1) m_cnt++;
            if (nxt == 2) m_side = 0;
            else if (nxt == 3) m_side = 1;
            m_state = nxt;
            // accept a value once the last D synchronized samples all agree on something new
            for (int i = 0; i < D - 1; i++) hist[i] = hist[i + 1];
            hist[D - 1] = d2;
            same = 1'b1;
            for (int i = 1; i < D; i++) if (hist[i] != hist[0]) same = 1'b0;
            if (same && hist[0] != m_filt) m_filt = hist[0];
            d2 = d1;
            d1 = int'(sensor);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model_l", 32'(l_mode), 32'(m_l));
        check("model_r", 32'(r_mode), 32'(m_r));
        check("model_state", 32'(state), 32'(m_st));
        check("model_lost", 32'(lost), 32'(m_lost));
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    initial begin
        int val;
        int hold;

        // reset with the line centred
        rst = 1'b0; en = 1'b1; sensor = 3'b010;
        ticks(3);
        check("rst_state", 32'(state), 0);
        check("rst_l", 32'(l_mode), 0);
        check("rst_r", 32'(r_mode), 0);
        rst = 1'b1;
        ticks(7);
        check("rel7_l", 32'(l_mode), INNER);
        check("rel7_r", 32'(r_mode), 1);
        tick();
        check("rel8_l", 32'(l_mode), 1);
        check("rel8_r", 32'(r_mode), 1);

        // short glitch is ignored
        ticks(4);
        for (int i = 0; i < 13; i++) begin
            sensor = (i < 3) ? 3'b100 : 3'b010;
            tick();
            check("glitch_l", 32'(l_mode), 1);
            check("glitch_r", 32'(r_mode), 1);
        end

        // left turn latency
        sensor = 3'b110;
        ticks(7);
        check("turn7_l", 32'(l_mode), 1);
        tick();
        check("turn8_l", 32'(l_mode), INNER);
        check("turn8_r", 32'(r_mode), 1);

        // right, then lose the line
        sensor = 3'b011;
        ticks(8);
        check("right_l", 32'(l_mode), 1);
        check("right_r", 32'(r_mode), INNER);
        sensor = 3'b000;
        ticks(8);
        check("search_state", 32'(state), 4);
        check("search_l", 32'(l_mode), 1);
        check("search_r", 32'(r_mode), INNER);
        ticks(15);
        check("search_end_state", 32'(state), 4);
        tick();
        check("halt_state", 32'(state), 5);
        check("halt_lost", 32'(lost), 1);
        check("halt_l", 32'(l_mode), 0);
        check("halt_r", 32'(r_mode), 0);
        sensor = 3'b010;
        ticks(12);
        check("halt_hold", 32'(state), 5);
        en = 1'b0;
        ticks(2);
        check("halt_exit", 32'(state), 0);
        check("halt_exit_lost", 32'(lost), 0);

        // line found on the last search count
        en = 1'b1;
        ticks(10);
        check("recov_fwd", 32'(state), 1);
        sensor = 3'b000;
        ticks(16);
        sensor = 3'b001;
        ticks(8);
        check("recov_state", 32'(state), 3);
        check("recov_lost", 32'(lost), 0);
        check("recov_l", 32'(l_mode), 1);
        ticks(20);
        check("recov_hold", 32'(state), 3);

        // disable in the middle of a turn
        sensor = 3'b100;
        ticks(10);
        check("dis_left", 32'(state), 2);
        en = 1'b0;
        tick();
        check("dis_edge1", 32'(state), 2);
        tick();
        check("dis_edge2", 32'(state), 0);
        check("dis_l", 32'(l_mode), 0);
        check("dis_r", 32'(r_mode), 0);
        en = 1'b1;

        // randomized segments with occasional disable and reset
        for (int s = 0; s < 160; s++) begin
            val  = int'($urandom_range(0, 7));
            hold = (val == 0) ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 12));
            sensor = 3'(val);
            en = ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b0;
                tick();
                rst = 1'b1;
            end
            ticks(hold);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
